// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative multiplier mul_iter_fsm:
//   - state_t  : FSM state encoding (IDLE / RUN / DONE)
//   - calc_n   : number of limbs per operand, N = WIDTH / LIMB
//   - calc_cw  : width of the limb counters, $clog2(N) with a minimum of 1
//   - cfg_ok   : legality of a WIDTH / LIMB pairing (multiple of LIMB, N in 1..8)
// -----------------------------------------------------------------------------
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_n(input int width, input int limb);
    return width / limb;
  endfunction

  function automatic int calc_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok(input int width, input int limb);
    return (limb > 0) && (width > 0) && ((width % limb) == 0) &&
           ((width / limb) >= 1) && ((width / limb) <= 8);
  endfunction

endpackage

// File: rtl/mul_limb.sv
// -----------------------------------------------------------------------------
// mul_limb
// Purely combinational unsigned LIMB x LIMB -> 2*LIMB multiplier. Kept as its
// own module so it can be replaced by a vendor DSP primitive without touching
// the sequencing logic.
// Ports:
//   a_i  in  LIMB      unsigned multiplicand limb
//   b_i  in  LIMB      unsigned multiplier limb
//   p_o  out 2*LIMB    full product
// -----------------------------------------------------------------------------
module mul_limb
  import mul_pkg::*;
#(
  parameter int LIMB = 16
) (
  input  logic [LIMB-1:0]   a_i,
  input  logic [LIMB-1:0]   b_i,
  output logic [2*LIMB-1:0] p_o
);

  assign p_o = (2*LIMB)'(a_i) * (2*LIMB)'(b_i);

endmodule

// File: rtl/mul_iter_fsm.sv
// -----------------------------------------------------------------------------
// mul_iter_fsm
// Iterative WIDTH x WIDTH multiplier producing a 2*WIDTH product from N*N
// limb partial products (N = WIDTH/LIMB), one per clock, through a single
// shared mul_limb instance. Returns either the low or the high product half.
//
// Ports:
//   clk   in   1      clock, rising edge
//   rst   in   1      asynchronous active-high reset
//   req   in   1      start pulse; p0/p1/hi/sgn sampled on the same edge
//   p0    in   WIDTH  multiplicand
//   p1    in   WIDTH  multiplier
//   hi    in   1      0: return product[WIDTH-1:0], 1: product[2*WIDTH-1:WIDTH]
//   sgn   in   1      signed-operand mode (only with MUL_ITER_SIGNED_EN)
//   busy  out  1      high while in RUN or DONE
//   ack   out  1      one-cycle result-valid pulse
//   out   out  WIDTH  selected product half, held until the next req
//
// Build option:
//   MUL_ITER_SIGNED_EN  when defined, sgn=1 treats operands as two's
//                       complement (magnitudes multiplied, result negated
//                       when the signs differ). When undefined, sgn is
//                       ignored and no negation logic exists.
//
// Timing: ack rises on the (N*N+1)-th rising edge after the req edge.
// A req in any state restarts the operation and takes priority over
// every other transition, including the DONE -> IDLE ack edge.
// -----------------------------------------------------------------------------
module mul_iter_fsm
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LIMB  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] p1,
  input  logic             hi,
  input  logic             sgn,
  output logic             busy,
  output logic             ack,
  output logic [WIDTH-1:0] out
);

  localparam int N  = calc_n(WIDTH, LIMB);
  localparam int CW = calc_cw(N);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!cfg_ok(WIDTH, LIMB)) begin : g_cfg_check
    $error("mul_iter_fsm: WIDTH must be a multiple of LIMB with WIDTH/LIMB in 1..8");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             hi_q, hi_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ack_q, ack_d;
  logic [CW-1:0]    i_q, i_d;
  logic [CW-1:0]    j_q, j_d;

  // Operand magnitudes presented at the req edge, and the final signed product.
  logic [WIDTH-1:0] mag0, mag1;
  logic [PW-1:0]    prod;

  logic [LIMB-1:0]   limb_a, limb_b;
  logic [2*LIMB-1:0] pp;
  logic [PW-1:0]     pp_sh;

`ifdef MUL_ITER_SIGNED_EN
  logic neg_q;

  // A most-negative operand maps to itself, which is exactly its magnitude
  // when read as an unsigned WIDTH-bit value.
  always_comb begin
    mag0 = (sgn && p0[WIDTH-1]) ? -p0 : p0;
    mag1 = (sgn && p1[WIDTH-1]) ? -p1 : p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (req) begin
      neg_q <= sgn & (p0[WIDTH-1] ^ p1[WIDTH-1]);
    end
  end

  assign prod = neg_q ? -acc_q : acc_q;
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign mag0       = p0;
  assign mag1       = p1;
  assign prod       = acc_q;
`endif

  // ---- limb select and shared multiplier ----
  assign limb_a = a_q[LIMB*int'(i_q) +: LIMB];
  assign limb_b = b_q[LIMB*int'(j_q) +: LIMB];

  mul_limb #(
    .LIMB (LIMB)
  ) u_mul_limb (
    .a_i (limb_a),
    .b_i (limb_b),
    .p_o (pp)
  );

  // Partial product aligned to limb position i+j; bits past PW fall off.
  assign pp_sh = PW'(pp) << (LIMB * (int'(i_q) + int'(j_q)));

  // ---- next-state / datapath control ----
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ack_d   = 1'b0;
    i_d     = i_q;
    j_d     = j_q;

    if (req) begin
      // Restart from any state; an in-flight operation is dropped.
      a_d     = mag0;
      b_d     = mag1;
      hi_d    = hi;
      acc_d   = '0;
      out_d   = '0;
      i_d     = '0;
      j_d     = '0;
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        RUN: begin
          acc_d = acc_q + pp_sh;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = DONE;
            end else begin
              i_d = i_q + CW'(1);
            end
          end else begin
            j_d = j_q + CW'(1);
          end
        end
        DONE: begin
          out_d   = hi_q ? prod[PW-1:WIDTH] : prod[WIDTH-1:0];
          ack_d   = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
      ack_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign ack  = ack_q;
  assign out  = out_q;

endmodule

// File: tb/tb_mul_iter_fsm.sv
// -----------------------------------------------------------------------------
// tb_mul_iter_fsm
// Bench for mul_iter_fsm with two instances: 32/16 (N=2) and 64/16 (N=4).
// Directed vectors come from a table; random operations are compared against
// a reference computed with plain wide arithmetic on sign- or zero-extended
// operands. Hand-written sequences cover restart, held req, req on the ack
// edge and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mul_iter_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        req_a = 1'b0, hi_a = 1'b0, sgn_a = 1'b0;
  logic [31:0] p0_a = '0, p1_a = '0;
  logic [31:0] out_a;
  logic        busy_a, ack_a;

  logic        req_b = 1'b0, hi_b = 1'b0, sgn_b = 1'b0;
  logic [63:0] p0_b = '0, p1_b = '0;
  logic [63:0] out_b;
  logic        busy_b, ack_b;

  mul_iter_fsm #(.WIDTH(32), .LIMB(16)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .p0(p0_a), .p1(p1_a), .hi(hi_a),
    .sgn(sgn_a), .busy(busy_a), .ack(ack_a), .out(out_a)
  );

  mul_iter_fsm #(.WIDTH(64), .LIMB(16)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .p0(p0_b), .p1(p1_b), .hi(hi_b),
    .sgn(sgn_b), .busy(busy_b), .ack(ack_b), .out(out_b)
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    int          w;
    logic [63:0] a;
    logic [63:0] b;
    logic        hi;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic add(input int w, input logic [63:0] a, input logic [63:0] b,
                     input logic h, input logic s, input logic [63:0] e);
    vec_t v;
    v.w = w; v.a = a; v.b = b; v.hi = h; v.sgn = s; v.exp = e;
    vecs.push_back(v);
  endtask

  // Reference: product of the operands extended to 128 bits (sign-extended
  // only when signed mode is built and requested), then the requested half.
  function automatic logic [63:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic h,
                                        input logic s);
    logic [127:0] ea, eb, p;
    logic         en;
`ifdef MUL_ITER_SIGNED_EN
    en = s;
`else
    en = 1'b0;
    if (s) en = 1'b0;
`endif
    if (w == 32) begin
      ea = en ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
      eb = en ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
      p  = ea * eb;
      return h ? {32'b0, p[63:32]} : {32'b0, p[31:0]};
    end else begin
      ea = en ? {{64{a[63]}}, a} : {64'b0, a};
      eb = en ? {{64{b[63]}}, b} : {64'b0, b};
      p  = ea * eb;
      return h ? p[127:64] : p[63:0];
    end
  endfunction

  task automatic drive(input int w, input logic r, input logic [63:0] a,
                       input logic [63:0] b, input logic h, input logic s);
    if (w == 32) begin
      req_a = r; p0_a = a[31:0]; p1_a = b[31:0]; hi_a = h; sgn_a = s;
    end else begin
      req_b = r; p0_b = a; p1_b = b; hi_b = h; sgn_b = s;
    end
  endtask

  function automatic logic ackv(input int w);
    return (w == 32) ? ack_a : ack_b;
  endfunction

  function automatic logic busyv(input int w);
    return (w == 32) ? busy_a : busy_b;
  endfunction

  function automatic logic [63:0] outv(input int w);
    return (w == 32) ? {32'b0, out_a} : out_b;
  endfunction

  // One complete operation: req for one edge, then garbage on the inputs.
  // Checks result, latency, busy length, and the single-cycle ack pulse.
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic h, input logic s, input logic [63:0] exp,
                        input string name);
    int          lat, busy_cnt, exp_lat;
    logic        got_ack;
    logic [63:0] res;
    exp_lat = (w == 32) ? 5 : 17;
    @(negedge clk);
    drive(w, 1'b1, a, b, h, s);
    @(negedge clk);
    drive(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    busy_cnt = busyv(w) ? 1 : 0;
    lat      = 0;
    got_ack  = 1'b0;
    while (!got_ack && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ackv(w)) got_ack = 1'b1;
      else if (busyv(w)) busy_cnt++;
    end
    res = outv(w);
    chk({name, " out"}, res, exp);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    @(posedge clk); #1;
    chk({name, " ack drop"}, 64'(ackv(w)), 64'd0);
    chk({name, " out hold"}, outv(w), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          acks, first;
    logic [63:0] ra, rb;
    logic        rh, rs;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset ack32", 64'(ack_a), 64'd0);
    chk("reset busy32", 64'(busy_a), 64'd0);
    chk("reset out32", 64'(out_a), 64'd0);
    chk("reset ack64", 64'(ack_b), 64'd0);
    chk("reset busy64", 64'(busy_b), 64'd0);
    chk("reset out64", out_b, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- directed table ----
    add(32, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 64'h00000001);
    add(32, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFE);
    add(32, 64'hFFFFFFFE, 64'h3,        1'b1, 1'b0, 64'h00000002);
    add(32, 64'hFFFFFFFE, 64'h3,        1'b0, 1'b0, 64'hFFFFFFFA);
    add(32, 64'h7,        64'h9,        1'b0, 1'b0, 64'd63);
    add(32, 64'h0,        64'hFFFFFFFF, 1'b1, 1'b0, 64'h0);
    add(32, 64'h10000,    64'h10000,    1'b1, 1'b0, 64'h1);
    add(32, 64'h10000,    64'h10000,    1'b0, 1'b0, 64'h0);
    add(32, 64'h80000000, 64'h2,        1'b1, 1'b0, 64'h1);
`ifdef MUL_ITER_SIGNED_EN
    add(32, 64'hFFFFFFFE, 64'h3,        1'b0, 1'b1, 64'hFFFFFFFA);
    add(32, 64'hFFFFFFFE, 64'h3,        1'b1, 1'b1, 64'hFFFFFFFF);
    add(32, 64'h80000000, 64'h80000000, 1'b1, 1'b1, 64'h40000000);
    add(32, 64'h80000000, 64'h80000000, 1'b0, 1'b1, 64'h0);
    add(32, 64'h7,        64'h9,        1'b0, 1'b1, 64'd63);
`else
    add(32, 64'hFFFFFFFE, 64'h3,        1'b1, 1'b1, 64'h00000002);
    add(32, 64'h80000000, 64'h80000000, 1'b1, 1'b1, 64'h40000000);
`endif
    add(64, 64'h0000000100000000, 64'h0000000100000000, 1'b1, 1'b0, 64'h1);
    add(64, 64'h0000000100000000, 64'h0000000100000000, 1'b0, 1'b0, 64'h0);
    add(64, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 64'h1);
    add(64, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFE);

    for (int k = 0; k < vecs.size(); k++) begin
      run_op(vecs[k].w, vecs[k].a, vecs[k].b, vecs[k].hi, vecs[k].sgn,
             vecs[k].exp, $sformatf("vec%0d", k));
    end

    // ---- restart two cycles into an operation ----
    @(negedge clk); drive(32, 1'b1, 64'd7, 64'd9, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b1, 64'd5, 64'd6, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 64'd99, 64'd99, 1'b1, 1'b0);
    acks = 0; first = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (ack_a) begin acks++; if (first == 0) first = e; end
    end
    chk("restart ack count", 64'(acks), 64'd1);
    chk("restart ack edge", 64'(first), 64'd5);
    chk("restart out", 64'(out_a), 64'd30);

    // ---- req on the edge where ack would rise ----
    @(negedge clk); drive(32, 1'b1, 64'd7, 64'd9, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    drive(32, 1'b1, 64'd3, 64'd4, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ack-edge req no ack", 64'(ack_a), 64'd0);
    chk("ack-edge req busy", 64'(busy_a), 64'd1);
    @(negedge clk); drive(32, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    acks = 0; first = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (ack_a) begin acks++; if (first == 0) first = e; end
    end
    chk("ack-edge req acks", 64'(acks), 64'd1);
    chk("ack-edge req edge", 64'(first), 64'd5);
    chk("ack-edge req out", 64'(out_a), 64'd12);

    // ---- req held for three edges ----
    @(negedge clk); drive(32, 1'b1, 64'd11, 64'd13, 1'b0, 1'b0);
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack_a) acks++;
      @(negedge clk);
    end
    drive(32, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    first = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (ack_a) begin acks++; if (first == 0) first = e; end
    end
    chk("held req acks", 64'(acks), 64'd1);
    chk("held req edge", 64'(first), 64'd5);
    chk("held req out", 64'(out_a), 64'd143);

    // ---- asynchronous reset ----
    run_op(32, 64'd7, 64'd9, 1'b0, 1'b0, 64'd63, "pre-reset");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async rst out idle", 64'(out_a), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); drive(32, 1'b1, 64'd7, 64'd9, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("run busy before rst", 64'(busy_a), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst busy", 64'(busy_a), 64'd0);
    chk("async rst ack", 64'(ack_a), 64'd0);
    chk("async rst out", 64'(out_a), 64'd0);
    @(negedge clk); rst = 1'b0;
    acks = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (ack_a) acks++;
    end
    chk("no ack after rst", 64'(acks), 64'd0);
    run_op(32, 64'd12, 64'd12, 1'b0, 1'b0, 64'd144, "post-reset");

    // ---- randomized operations vs reference ----
    for (int k = 0; k < 40; k++) begin
      int w;
      w  = (k % 5 == 4) ? 64 : 32;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = (w == 32) ? 64'h80000000 : 64'h8000000000000000;
        2: ra = '0;
        default: ;
      endcase
      if (w == 32) begin ra[63:32] = '0; rb[63:32] = '0; end
      rh = 1'($urandom);
      rs = 1'($urandom);
      run_op(w, ra, rb, rh, rs, model(w, ra, rb, rh, rs), $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_iter_fsm.md
Name: mul_iter_fsm

Overview:
Parametrised iterative multiplier and the next generation of the 32x32 FSM multiplier. It computes the full 2*WIDTH-bit product of two WIDTH-bit operands using one shared LIMB x LIMB combinational multiplier, with one partial product per cycle. Either the low or the high half of the product is returned, under the same req/ack handshake. It sits beside the core ALU as the long-latency MUL/MULH unit.

Parameters:
WIDTH, 32, operand width; must be a multiple of LIMB.
LIMB, 16, limb width of the shared multiplier; N = WIDTH/LIMB must be in 1..8.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  1  start pulse; operands and mode sampled on the same edge.
p0  in  WIDTH  multiplicand.
p1  in  WIDTH  multiplier.
hi  in  1  0 = return product[WIDTH-1:0]; 1 = return product[2*WIDTH-1:WIDTH].
sgn  in  1  signed-operand mode; honoured only with the optional feature.
busy  out  1  high in RUN and DONE.
ack  out  1  one-cycle result-valid pulse.
out  out  WIDTH  selected product half; held after ack until the next req.

Behaviour:
- Reset (asynchronous): ack=0, busy=0, out=0, state=IDLE, acc=0, limb counters=0.
- States: IDLE, RUN, DONE.
- req high in any state:
  - Latch operand magnitudes, hi, and the result-negate flag.
  - acc<=0, out<=0, ack<=0, i=j=0, state<=RUN.
  - An in-flight operation is silently abandoned. req has priority over every other transition.
- RUN, one cycle per (i,j) pair, N*N cycles in total:
  - acc <= acc + (A[i]*B[j] << LIMB*(i+j)).
  - A[i] and B[j] are limbs of the latched operands; the sum is 2*WIDTH bits wide and carries out of the top are dropped.
  - j increments; on wrap j<=0 and i increments. After the pair (N-1,N-1), state<=DONE.
- DONE (one cycle):
  - P = neg ? -acc : acc (2*WIDTH two's complement).
  - out <= hi ? P[2*WIDTH-1:WIDTH] : P[WIDTH-1:0].
  - ack<=1 for exactly one cycle, then state<=IDLE.
- IDLE: ack<=0; out holds its value.
- Latency: ack rises on the (N*N+1)-th rising edge after the edge that sampled req. For 32/16 this is 5 edges.
- Edge cases:
  - req asserted on the same edge ack would rise: the restart wins and no ack is issued.
  - req held high for multiple cycles: the operation restarts every cycle and completes only after req drops.
  - N=1: one RUN cycle, ack on the 2nd edge.
  - Operand changes after the req edge are ignored.

Optional Feature:
MUL_ITER_SIGNED_EN.
- Defined:
  - When sgn=1 on the req edge, each negative operand is replaced by its two's-complement magnitude, and neg = p0[WIDTH-1]^p1[WIDTH-1].
  - Most-negative operands are handled by treating the magnitude as unsigned WIDTH bits.
  - When sgn=0, the operation is unsigned.
- Undefined: sgn is ignored, neg is tied to 0, and no negation logic is built; the operation is purely unsigned.

Decomposition:
- mul_pkg holds:
  - the state typedef (IDLE/RUN/DONE);
  - localparam functions for N and the counter width ($clog2(N), minimum 1);
  - the WIDTH%LIMB elaboration check.
- Sub-module mul_limb: purely combinational unsigned LIMB x LIMB -> 2*LIMB multiplier, instantiated once, so it can be swapped for a DSP primitive.

Test Plan:
- 32/16, unsigned, p0=p1=0xFFFFFFFF:
  - hi=0 -> out=0x00000001, ack on 5th edge, busy high for 5 cycles.
  - hi=1 -> out=0xFFFFFFFE.
- SIGNED_EN, sgn=1, p0=0xFFFFFFFE (-2), p1=3:
  - hi=0 -> out=0xFFFFFFFA.
  - hi=1 -> out=0xFFFFFFFF.
  - Same operands with sgn=0, hi=1 -> out=0x00000002.
- SIGNED_EN, sgn=1, p0=p1=0x80000000, hi=1 -> out=0x40000000; hi=0 -> out=0.
- Restart: req with 7*9, then req again 2 cycles later with 5*6, hi=0 -> exactly one ack, out=30, 5 edges after the second req.
- Reset mid-operation: assert rst during RUN -> ack, busy and out go to 0 immediately and no ack follows. A new req 12*12 -> out=144.
- WIDTH=64/LIMB=16, p0=0x0000000100000000, p1=0x0000000100000000:
  - hi=1 -> out=0x1.
  - hi=0 -> out=0.
  - ack on the 17th edge.
